axis_pkt_arb_2to1: RTL and testbench

AXIS_PKT_ARB_2TO1 -- requirements
Module: axis_pkt_arb_2to1

---
 rtl/axis_pkt_arb_2to1_if.sv | 13 +
 rtl/axis_pkt_arb_2to1.sv | 86 ++++++++
 tb/tb_axis_pkt_arb_2to1.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_arb_2to1_if.sv
// axis_if: AXI4-Stream bundle used for the arbiter's requester and output ports.
interface axis_if #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = DATA_W/8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  modport master(output tvalid, tlast, tdata, tkeep, input tready);
  modport slave(input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/axis_pkt_arb_2to1.sv
// axis_pkt_arb_2to1: packet-locked round-robin 2:1 AXI4-Stream arbiter with a registered output stage.
module axis_pkt_arb_2to1 #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = DATA_W/8,
  parameter int CNT_W  = 16
)(
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  axis_if.slave            s0_axis,
  axis_if.slave            s1_axis,
  axis_if.master           m_axis,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;
  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              vld_q, vld_d, lst_q, lst_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [KEEP_W-1:0] kep_q, kep_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic              stage_ready, acc0, acc1;
  assign stage_ready     = !vld_q | m_axis.tready;
  assign s0_axis.tready  = (state_q == GNT0) & stage_ready;
  assign s1_axis.tready  = (state_q == GNT1) & stage_ready;
  assign acc0            = s0_axis.tvalid & s0_axis.tready;
  assign acc1            = s1_axis.tvalid & s1_axis.tready;
  assign m_axis.tvalid   = vld_q;
  assign m_axis.tlast    = lst_q;
  assign m_axis.tdata    = dat_q;
  assign m_axis.tkeep    = kep_q;
  assign grant           = {state_q == GNT1, state_q == GNT0};
  assign busy            = (state_q != IDLE) | vld_q;
  assign pkt_cnt0        = cnt0_q;
  assign pkt_cnt1        = cnt1_q;
  // last_q names the previous owner; a tie goes to the other port
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && (!s1_axis.tvalid || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (s1_axis.tvalid) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    state_d = (acc0 && s0_axis.tlast) ? IDLE : GNT0;
      GNT1:    state_d = (acc1 && s1_axis.tlast) ? IDLE : GNT1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    vld_d  = (acc0 | acc1) ? 1'b1 : stage_ready ? 1'b0 : vld_q;
    dat_d  = acc1 ? s1_axis.tdata : acc0 ? s0_axis.tdata : dat_q;
    kep_d  = acc1 ? s1_axis.tkeep : acc0 ? s0_axis.tkeep : kep_q;
    lst_d  = acc1 ? s1_axis.tlast : acc0 ? s0_axis.tlast : lst_q;
    cnt0_d = cnt0_q + CNT_W'(acc0 & s0_axis.tlast);
    cnt1_d = cnt1_q + CNT_W'(acc1 & s1_axis.tlast);
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      vld_q   <= 1'b0;
      lst_q   <= 1'b0;
      dat_q   <= '0;
      kep_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      dat_q   <= dat_d;
      kep_q   <= kep_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arb_2to1.sv
// tb_axis_pkt_arb_2to1: randomized requesters and sink checked against a packet-level scoreboard and timing rules.
module tb_axis_pkt_arb_2to1;
  localparam int DW = 256, KW = DW/8, CW = 4;
  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  logic clk = 1'b0, rstn = 1'b1;
  logic [1:0] grant;
  logic busy;
  logic [CW-1:0] cnt0, cnt1;
  axis_if #(.DATA_W(DW)) s0(), s1(), m();
  axis_pkt_arb_2to1 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn),
    .s0_axis(s0), .s1_axis(s1), .m_axis(m),
    .grant(grant), .busy(busy), .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
  );
  always #5 clk = ~clk;
  beat_t q0[$], q1[$], e0[$], e1[$];
  int tests, fails, cyc, p_v, p_r, rdy_mode, n, r1_early, total, len;
  bit a0, a1, tog, in_pkt, cur_port, stall_prev;
  logic [DW+KW+1:0] stall_v;
  logic [1:0] g_log [4096];
  bit r1_log [4096];
  int out_cyc[$], last_in[2];
  bit out_port[$], pkt_order[$];
  int tie_cyc[6] = '{2, 3, 4, 6, 7, 8};
  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic make_pkt(input bit p, input int l);
    beat_t b;
    for (int i = 0; i < l; i++) begin
      for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom;
      b.d[DW-1] = p;
      b.k = $urandom;
      b.l = (i == l-1);
      if (p) begin q1.push_back(b); e1.push_back(b); end
      else begin q0.push_back(b); e0.push_back(b); end
    end
  endtask
  // one clock: drive at posedge+1, sample at negedge, retire accepted beats after the edge
  task automatic step();
    beat_t b, x;
    bit p, have;
    s0.tvalid = (q0.size() != 0) && ((s0.tvalid && !a0) || ($urandom_range(99) < p_v));
    s1.tvalid = (q1.size() != 0) && ((s1.tvalid && !a1) || ($urandom_range(99) < p_v));
    if (q0.size() != 0) {s0.tdata, s0.tkeep, s0.tlast} = q0[0];
    if (q1.size() != 0) {s1.tdata, s1.tkeep, s1.tlast} = q1[0];
    m.tready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? tog : ($urandom_range(99) < p_r);
    tog = ~tog;
    @(negedge clk);
    a0 = s0.tvalid & s0.tready;
    a1 = s1.tvalid & s1.tready;
    if (cyc < 4096) begin
      g_log[cyc]  = grant;
      r1_log[cyc] = s1.tready;
    end
    if (stall_prev) chk("stall_hold", {m.tvalid, m.tdata, m.tkeep, m.tlast}, stall_v);
    stall_prev = m.tvalid & !m.tready;
    stall_v = {m.tvalid, m.tdata, m.tkeep, m.tlast};
    if (a0 && s0.tlast) last_in[0] = cyc;
    if (a1 && s1.tlast) last_in[1] = cyc;
    if (m.tvalid && m.tready) begin
      b = {m.tdata, m.tkeep, m.tlast};
      p = b.d[DW-1];
      if (in_pkt) chk("no_interleave", p, cur_port);
      else begin
        cur_port = p;
        pkt_order.push_back(p);
      end
      in_pkt = !b.l;
      have = p ? (e1.size() != 0) : (e0.size() != 0);
      chk("beat_pending", have, 1);
      if (have) begin
        if (p) x = e1.pop_front();
        else x = e0.pop_front();
        chk("beat", b, x);
      end
      out_cyc.push_back(cyc);
      out_port.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
  endtask
  task automatic do_reset(input bit check);
    rstn = 1'b0;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    s0.tvalid = 1'b0;
    s1.tvalid = 1'b0;
    a0 = 0; a1 = 0; in_pkt = 0; stall_prev = 0;
    #1;
    if (check) begin
      chk("rst_m_tvalid", m.tvalid, 0);
      chk("rst_m_tlast", m.tlast, 0);
      chk("rst_m_tdata", m.tdata, 0);
      chk("rst_m_tkeep", m.tkeep, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s0_tready", s0.tready, 0);
      chk("rst_s1_tready", s1.tready, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  task automatic new_test();
    cyc = 0;
    out_cyc.delete(); out_port.delete(); pkt_order.delete();
    last_in[0] = -1;
    last_in[1] = -1;
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain_done", q0.size() + q1.size() + e0.size() + e1.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tests = 0; fails = 0; p_v = 100; p_r = 100; rdy_mode = 1; tog = 1;
    s0.tvalid = 0; s1.tvalid = 0; s0.tdata = '0; s1.tdata = '0;
    s0.tkeep = '0; s1.tkeep = '0; s0.tlast = 0; s1.tlast = 0; m.tready = 1;
    @(posedge clk);
    #1;
    do_reset(1);
    // tie right after reset: port 0 first, one arbitration cycle between packets
    new_test(); make_pkt(0, 3); make_pkt(1, 3); drain(50);
    chk("tie_beats", out_cyc.size(), 6);
    for (int i = 0; i < 6 && i < out_cyc.size(); i++) begin
      chk("tie_cyc", out_cyc[i], tie_cyc[i]);
      chk("tie_port", out_port[i], i >= 3);
    end
    chk("tie_grant_c1", g_log[1], 2'b01);
    chk("tie_idle_c4", g_log[4], 2'b00);
    chk("tie_grant_c5", g_log[5], 2'b10);
    chk("tie_cnt0", cnt0, 1);
    chk("tie_cnt1", cnt1, 1);
    // lock: port 1 waits with tvalid high through a whole 8-beat port 0 packet
    new_test(); make_pkt(0, 8); make_pkt(1, 2); drain(60);
    chk("lock_last0", last_in[0], 8);
    r1_early = 0;
    for (int i = 0; i <= last_in[0] + 1 && i < 4096; i++) r1_early += int'(r1_log[i]);
    chk("lock_s1_ready_low", r1_early, 0);
    chk("lock_s1_ready_gnt", r1_log[10], 1);
    chk("lock_pkts", pkt_order.size(), 2);
    if (pkt_order.size() == 2) chk("lock_first", pkt_order[0], 0);
    // backpressure 1-0-1-0 during a 4-beat packet
    new_test(); rdy_mode = 2; tog = 1; make_pkt(0, 4); drain(40); rdy_mode = 1;
    chk("bp_beats", out_cyc.size(), 4);
    repeat (2) step();
    chk("bp_busy_idle", busy, 0);
    chk("bp_grant_idle", grant, 0);
    // counter wrap with 17 single-beat packets
    do_reset(0);
    new_test(); repeat (17) make_pkt(1, 1); drain(80);
    chk("wrap_cnt1", cnt1, 1);
    chk("wrap_cnt0", cnt0, 0);
    chk("wrap_last_in", last_in[1], 33);
    chk("wrap_beats", out_cyc.size(), 17);
    if (out_cyc.size() == 17) chk("wrap_last_out", out_cyc[16], 34);
    // reset while a 5-beat packet is in flight
    new_test(); make_pkt(0, 5);
    n = 0;
    while (out_cyc.size() < 2 && n < 20) begin step(); n++; end
    chk("rmp_reached", out_cyc.size(), 2);
    chk("rmp_busy", busy, 1);
    do_reset(1);
    new_test(); make_pkt(0, 1); make_pkt(1, 1); drain(20);
    chk("rmp_pkts", pkt_order.size(), 2);
    if (pkt_order.size() == 2) begin
      chk("rmp_first_cyc", out_cyc[0], 2);
      chk("rmp_tie_port0", pkt_order[0], 0);
      chk("rmp_then_port1", pkt_order[1], 1);
    end
    chk("rmp_cnt0", cnt0, 1);
    chk("rmp_cnt1", cnt1, 1);
    // random gaps and backpressure
    do_reset(0);
    new_test(); p_v = 60; p_r = 70; rdy_mode = 0;
    for (int i = 0; i < 20; i++) begin
      make_pkt(0, $urandom_range(1, 6));
      make_pkt(1, $urandom_range(1, 6));
    end
    drain(3000);
    repeat (3) step();
    chk("rnd_cnt0", cnt0, 20 % (1 << CW));
    chk("rnd_cnt1", cnt1, 20 % (1 << CW));
    chk("rnd_busy_idle", busy, 0);
    // saturated: strict alternation, each packet costs len+1 cycles
    do_reset(0);
    new_test(); p_v = 100; rdy_mode = 1; total = 0;
    for (int i = 0; i < 5; i++) begin
      len = $urandom_range(1, 6); total += len + 1; make_pkt(0, len);
      len = $urandom_range(1, 6); total += len + 1; make_pkt(1, len);
    end
    drain(200);
    chk("b2b_pkts", pkt_order.size(), 10);
    for (int i = 0; i < 10 && i < pkt_order.size(); i++) chk("b2b_order", pkt_order[i], i % 2);
    if (out_cyc.size() != 0) chk("b2b_last_out", out_cyc[out_cyc.size()-1], total);
    chk("b2b_cnt0", cnt0, 5);
    chk("b2b_cnt1", cnt1, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
